// File: rtl/operand_fetch_pkg.sv
// Shared LITE-16 register-file constants and operand-fetch buffer state encoding.
// No logic; imported by the operand-fetch top and its word-select sub-module.
// No backpressure.
package operand_fetch_pkg;

    localparam int LITE16_DATA_WIDTH = 16;
    localparam int LITE16_NUM_REGS   = 16;
    localparam int LITE16_IDX_WIDTH  = 4;
    localparam int LITE16_TAG_WIDTH  = 4;

    // Occupancy of the output register + skid register pair
    typedef enum logic [1:0] {
        FETCH_EMPTY = 2'd0,
        FETCH_ONE   = 2'd1,
        FETCH_FULL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/reg_select.sv
// Index -> register word mux over the flat read bus, with same-cycle write bypass.
// Purely combinational, zero latency.
// No backpressure.
module reg_select
    import operand_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = LITE16_DATA_WIDTH,
    parameter int NUM_REGS   = LITE16_NUM_REGS,
    parameter int IDX_WIDTH  = LITE16_IDX_WIDTH
) (
    input  logic [NUM_REGS*DATA_WIDTH-1:0] rf_data,
    input  logic [NUM_REGS-1:0]            wb_en,
    input  logic [DATA_WIDTH-1:0]          wb_data,
    input  logic [IDX_WIDTH-1:0]           idx,
    output logic [DATA_WIDTH-1:0]          word
);

    // A write landing on the selected register this cycle wins over the stale file contents
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == i[IDX_WIDTH-1:0]) begin
                word = wb_en[i] ? wb_data : rf_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Register-file read stage: snapshots two source operands plus tag on accept.
// Latency 1 cycle from accepting edge to out_valid; 1 op/cycle while out_ready=1.
// Output reg + one skid reg; req_ready is registered (!FULL), never combinational on out_ready.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = LITE16_DATA_WIDTH,
    parameter int NUM_REGS   = LITE16_NUM_REGS,
    parameter int IDX_WIDTH  = LITE16_IDX_WIDTH,
    parameter int TAG_WIDTH  = LITE16_TAG_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] rf_data,
    input  logic [NUM_REGS-1:0]            wb_en,
    input  logic [DATA_WIDTH-1:0]          wb_data,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [IDX_WIDTH-1:0]           req_rs_a,
    input  logic [IDX_WIDTH-1:0]           req_rs_b,
    input  logic [TAG_WIDTH-1:0]           req_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          op_a,
    output logic [DATA_WIDTH-1:0]          op_b,
    output logic [TAG_WIDTH-1:0]           out_tag
);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] a;
    } entry_t;

    fetch_state_t state_q, state_d;
    entry_t       out_q, skid_q, new_entry;
    logic         req_ready_q, out_valid_q;
    logic         accept, xfer;
    logic         load_out, load_skid, skid_to_out;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;

    reg_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_sel_a (
        .rf_data (rf_data),
        .wb_en   (wb_en),
        .wb_data (wb_data),
        .idx     (req_rs_a),
        .word    (sel_a)
    );

    reg_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_sel_b (
        .rf_data (rf_data),
        .wb_en   (wb_en),
        .wb_data (wb_data),
        .idx     (req_rs_b),
        .word    (sel_b)
    );

    assign accept    = req_valid & req_ready_q;
    assign xfer      = out_valid_q & out_ready;
    assign new_entry = '{tag: req_tag, b: sel_b, a: sel_a};

    // Next-state and datapath steering; the skid reg only fills when the output reg is stuck
    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state_q)
            FETCH_EMPTY: begin
                if (accept) begin
                    state_d  = FETCH_ONE;
                    load_out = 1'b1;
                end
            end
            FETCH_ONE: begin
                if (accept && xfer) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = FETCH_FULL;
                    load_skid = 1'b1;
                end else if (xfer) begin
                    state_d = FETCH_EMPTY;
                end
            end
            FETCH_FULL: begin
                if (xfer) begin
                    state_d     = FETCH_ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_d = FETCH_EMPTY;
        endcase
    end

    // State plus registered handshake outputs, decoded from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH_EMPTY;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d != FETCH_FULL);
            out_valid_q <= (state_d != FETCH_EMPTY);
        end
    end

    // Output and skid registers; entries are frozen once captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= new_entry;
            end else if (skid_to_out) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= new_entry;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign op_a      = out_q.a;
    assign op_b      = out_q.b;
    assign out_tag   = out_q.tag;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, fetch, bypass, backpressure, snapshot, async reset.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_operand_fetch;

    logic         clk;
    logic         rst;
    logic [255:0] rf_data;
    logic [15:0]  wb_en;
    logic [15:0]  wb_data;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_rs_a;
    logic [3:0]   req_rs_b;
    logic [3:0]   req_tag;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  op_a;
    logic [15:0]  op_b;
    logic [3:0]   out_tag;

    logic [15:0]  regs [16];
    int           n_checks;
    int           n_fail;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .rf_data   (rf_data),
        .wb_en     (wb_en),
        .wb_data   (wb_data),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs_a  (req_rs_a),
        .req_rs_b  (req_rs_b),
        .req_tag   (req_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flatten the modelled register file onto the read bus
    always_comb begin
        rf_data = '0;
        for (int i = 0; i < 16; i++) rf_data[i*16 +: 16] = regs[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        wb_en     = '0;
        wb_data   = '0;
        req_valid = 1'b0;
        req_rs_a  = '0;
        req_rs_b  = '0;
        req_tag   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        regs[3] = 16'h0123;
        regs[7] = 16'h4545;

        // 1: reset
        step();
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_op_a", {16'd0, op_a}, 32'h0000);
        check("rst_op_b", {16'd0, op_b}, 32'h0000);
        check("rst_out_tag", {28'd0, out_tag}, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // 2: basic fetch
        req_valid = 1'b1; req_rs_a = 4'd3; req_rs_b = 4'd7; req_tag = 4'd2;
        step();
        check("fetch_op_a", {16'd0, op_a}, 32'h0123);
        check("fetch_op_b", {16'd0, op_b}, 32'h4545);
        check("fetch_tag", {28'd0, out_tag}, 32'd2);
        check("fetch_valid", {31'd0, out_valid}, 32'd1);

        // 3: same-cycle bypass, one-hot then multi-hot
        wb_en = 16'h8000; wb_data = 16'hAEAE;
        req_rs_a = 4'd15; req_rs_b = 4'd7; req_tag = 4'd5;
        step();
        check("byp1_op_a", {16'd0, op_a}, 32'hAEAE);
        check("byp1_op_b", {16'd0, op_b}, 32'h4545);
        check("byp1_tag", {28'd0, out_tag}, 32'd5);
        wb_en = 16'hFFFF; wb_data = 16'h0000;
        req_rs_a = 4'd7; req_rs_b = 4'd3; req_tag = 4'd6;
        step();
        check("byp2_op_b", {16'd0, op_b}, 32'h0000);
        check("byp2_op_a", {16'd0, op_a}, 32'h0000);
        wb_en = '0; req_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_ready", {31'd0, req_ready}, 32'd1);

        // 4: backpressure, three back-to-back requests
        out_ready = 1'b0;
        req_valid = 1'b1; req_rs_a = 4'd3; req_rs_b = 4'd7; req_tag = 4'd1;
        step();
        check("bp1_valid", {31'd0, out_valid}, 32'd1);
        check("bp1_tag", {28'd0, out_tag}, 32'd1);
        check("bp1_ready", {31'd0, req_ready}, 32'd1);
        req_tag = 4'd2;
        step();
        check("bp2_ready", {31'd0, req_ready}, 32'd0);
        check("bp2_tag", {28'd0, out_tag}, 32'd1);
        req_tag = 4'd3;
        step();
        check("bp3_ready", {31'd0, req_ready}, 32'd0);
        check("bp3_tag", {28'd0, out_tag}, 32'd1);
        check("bp3_op_a", {16'd0, op_a}, 32'h0123);
        out_ready = 1'b1;
        step();
        check("bp4_tag", {28'd0, out_tag}, 32'd2);
        check("bp4_ready", {31'd0, req_ready}, 32'd1);
        step();
        check("bp5_tag", {28'd0, out_tag}, 32'd3);
        check("bp5_valid", {31'd0, out_valid}, 32'd1);
        req_valid = 1'b0;
        step();
        check("bp6_valid", {31'd0, out_valid}, 32'd0);

        // 5: snapshot while stalled, then overwrite r3
        out_ready = 1'b0;
        req_valid = 1'b1; req_rs_a = 4'd3; req_rs_b = 4'd3; req_tag = 4'd7;
        step();
        req_rs_b = 4'd7; req_tag = 4'd8;
        step();
        req_valid = 1'b0;
        wb_en = 16'h0008; wb_data = 16'hFFFF;
        step();
        regs[3] = 16'hFFFF; wb_en = '0;
        check("snap_out_tag", {28'd0, out_tag}, 32'd7);
        check("snap_op_a", {16'd0, op_a}, 32'h0123);
        check("snap_op_b_same_idx", {16'd0, op_b}, 32'h0123);
        step();
        check("snap_hold_op_a", {16'd0, op_a}, 32'h0123);
        out_ready = 1'b1;
        step();
        check("snap_skid_tag", {28'd0, out_tag}, 32'd8);
        check("snap_skid_op_a", {16'd0, op_a}, 32'h0123);
        check("snap_skid_op_b", {16'd0, op_b}, 32'h4545);

        // 6: async reset while FULL
        out_ready = 1'b0;
        req_valid = 1'b1; req_rs_a = 4'd7; req_rs_b = 4'd7; req_tag = 4'd9;
        step();
        req_valid = 1'b0;
        check("full_ready", {31'd0, req_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_ready", {31'd0, req_ready}, 32'd1);
        check("arst_op_a", {16'd0, op_a}, 32'h0000);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        req_valid = 1'b1; req_rs_a = 4'd3; req_rs_b = 4'd7; req_tag = 4'd4;
        step();
        check("after_rst_op_a", {16'd0, op_a}, 32'hFFFF);
        check("after_rst_op_b", {16'd0, op_b}, 32'h4545);
        check("after_rst_tag", {28'd0, out_tag}, 32'd4);
        check("after_rst_valid", {31'd0, out_valid}, 32'd1);
        req_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
